// File: rtl/pingpong_frame_arbiter_if.sv
// Purpose : bundles the host write port and display read port of pingpong_frame_arbiter.
// Latency : n/a (wires only).
// Backpressure: wr_ready gates the host write stream; display side has none.
// Ports   : slave = arbiter side, master = host/display-timing side.
//           Optional repeat_cnt exists only when PINGPONG_REPEAT_CNT_EN is defined.
interface pingpong_frame_arbiter_if #(
  parameter int ADDR_W = 10
);
  // host write side
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_buf;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en0;
  logic              wr_en1;
  // display read side
  logic              frame_start;
  logic              rd_inc;
  logic              rd_buf;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  // status
  logic              buf0_empty;
  logic              buf1_empty;
  logic              swap;
  logic              repeat_frame;
`ifdef PINGPONG_REPEAT_CNT_EN
  logic [7:0]        repeat_cnt;
`endif

  modport slave (
    input  wr_valid, frame_start, rd_inc,
    output wr_ready, wr_buf, wr_addr, wr_en0, wr_en1,
    output rd_buf, rd_addr, rd_valid,
    output buf0_empty, buf1_empty, swap, repeat_frame
`ifdef PINGPONG_REPEAT_CNT_EN
    , output repeat_cnt
`endif
  );

  modport master (
    output wr_valid, frame_start, rd_inc,
    input  wr_ready, wr_buf, wr_addr, wr_en0, wr_en1,
    input  rd_buf, rd_addr, rd_valid,
    input  buf0_empty, buf1_empty, swap, repeat_frame
`ifdef PINGPONG_REPEAT_CNT_EN
    , input repeat_cnt
`endif
  );
endinterface

// File: rtl/pingpong_frame_arbiter.sv
// Purpose : owns two frame buffers; writer fills one while scan-out shows the other, roles swap only at frame_start.
// Latency : all outputs registered (1 cycle) except wr_en0/wr_en1, which are combinational from wr_valid.
// Backpressure: wr_ready drops after the last word of a frame until the other buffer can be claimed.
// Ports   : clk, reset (async active-high); bus = pingpong_frame_arbiter_if.slave carrying
//           wr_valid/wr_ready/wr_buf/wr_addr/wr_en0/wr_en1, frame_start/rd_inc/rd_buf/rd_addr/rd_valid,
//           buf0_empty/buf1_empty/swap/repeat_frame.
// Option  : PINGPONG_REPEAT_CNT_EN adds bus.repeat_cnt, a saturating count of repeated frames cleared on swap.
module pingpong_frame_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int FRAME_WORDS = 640
) (
  input  logic                     clk,
  input  logic                     reset,
  pingpong_frame_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    SHOW  = 2'd3
  } buf_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  // registered state
  buf_state_t        st_q [2];
  logic              wr_buf_q;
  logic              wr_ready_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              rd_buf_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_valid_q;
  logic              swap_q;
  logic              repeat_q;

  // next-state
  buf_state_t        st_n [2];
  logic              wr_buf_n;
  logic              wr_ready_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic              rd_buf_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic              rd_valid_n;
  logic              swap_n;
  logic              repeat_n;

  logic accept;
  assign accept = bus.wr_valid & wr_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q[0]    <= FILL;
      st_q[1]    <= EMPTY;
      wr_buf_q   <= 1'b0;
      wr_ready_q <= 1'b1;
      wr_addr_q  <= '0;
      rd_buf_q   <= 1'b1;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      swap_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      st_q[0]    <= st_n[0];
      st_q[1]    <= st_n[1];
      wr_buf_q   <= wr_buf_n;
      wr_ready_q <= wr_ready_n;
      wr_addr_q  <= wr_addr_n;
      rd_buf_q   <= rd_buf_n;
      rd_addr_q  <= rd_addr_n;
      rd_valid_q <= rd_valid_n;
      swap_q     <= swap_n;
      repeat_q   <= repeat_n;
    end
  end

  // Every decision below looks only at registered state. The three buffer
  // updates never collide: a write touches the FILL buffer, a claim touches
  // an EMPTY buffer, and a swap touches only the FULL and SHOW buffers.
  always_comb begin
    st_n[0]    = st_q[0];
    st_n[1]    = st_q[1];
    wr_buf_n   = wr_buf_q;
    wr_ready_n = wr_ready_q;
    wr_addr_n  = wr_addr_q;
    rd_buf_n   = rd_buf_q;
    rd_addr_n  = rd_addr_q;
    rd_valid_n = rd_valid_q;
    swap_n     = 1'b0;
    repeat_n   = 1'b0;

    // writer: fill, then close the frame on its last word
    if (accept) begin
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_n        = '0;
        st_n[wr_buf_q]   = FULL;
        wr_ready_n       = 1'b0;
      end else begin
        wr_addr_n        = wr_addr_q + ONE;
      end
    end

    // writer idle: take the other buffer once scan-out has released it
    if (!wr_ready_q && st_q[~wr_buf_q] == EMPTY) begin
      wr_buf_n          = ~wr_buf_q;
      st_n[~wr_buf_q]   = FILL;
      wr_ready_n        = 1'b1;
    end

    // scan-out: rd_addr restarts on every frame, swap only if a frame is ready
    if (bus.frame_start) begin
      rd_addr_n = '0;
      if (st_q[~rd_buf_q] == FULL) begin
        st_n[~rd_buf_q] = SHOW;
        // the very first swap leaves a buffer that was never shown
        if (st_q[rd_buf_q] == SHOW) begin
          st_n[rd_buf_q] = EMPTY;
        end
        rd_buf_n   = ~rd_buf_q;
        rd_valid_n = 1'b1;
        swap_n     = 1'b1;
      end else begin
        repeat_n = rd_valid_q;
      end
    end else if (bus.rd_inc && rd_valid_q) begin
      rd_addr_n = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ONE;
    end
  end

`ifdef PINGPONG_REPEAT_CNT_EN
  logic [7:0] repeat_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      repeat_cnt_q <= 8'd0;
    end else if (swap_n) begin
      repeat_cnt_q <= 8'd0;
    end else if (repeat_n && repeat_cnt_q != 8'hff) begin
      repeat_cnt_q <= repeat_cnt_q + 8'd1;
    end
  end

  assign bus.repeat_cnt = repeat_cnt_q;
`endif

  assign bus.wr_ready     = wr_ready_q;
  assign bus.wr_buf       = wr_buf_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_en0       = accept & ~wr_buf_q;
  assign bus.wr_en1       = accept &  wr_buf_q;
  assign bus.rd_buf       = rd_buf_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.buf0_empty   = (st_q[0] == EMPTY);
  assign bus.buf1_empty   = (st_q[1] == EMPTY);
  assign bus.swap         = swap_q;
  assign bus.repeat_frame = repeat_q;

endmodule

// File: tb/tb_pingpong_frame_arbiter.sv
// Purpose : self-checking bench for pingpong_frame_arbiter with FRAME_WORDS=4.
// Latency : checks registered outputs 1 cycle after each applied vector; wr_en sampled before the edge.
// Backpressure: exercises writer starvation while both buffers are occupied.
module tb_pingpong_frame_arbiter;
  localparam int AW = 10;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pingpong_frame_arbiter_if #(.ADDR_W(AW)) bus ();

  pingpong_frame_arbiter #(.ADDR_W(AW), .FRAME_WORDS(FW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic          en0;
    logic          en1;
    logic          rdy;
    logic          wb;
    logic [AW-1:0] wa;
    logic          rb;
    logic [AW-1:0] ra;
    logic          rv;
    logic          b0e;
    logic          b1e;
    logic          sw;
    logic          rp;
  } obs_t;

  typedef struct packed {
    logic wv;
    logic fs;
    logic ri;
    obs_t exp;
  } vec_t;

  obs_t q[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(bit wv, bit fs, bit ri, bit e0, bit e1,
                              bit rdy, bit wb, int wa, bit rb, int ra,
                              bit rv, bit b0e, bit b1e, bit sw, bit rp);
    vec_t v;
    v.wv = wv; v.fs = fs; v.ri = ri;
    v.exp.en0 = e0; v.exp.en1 = e1;
    v.exp.rdy = rdy; v.exp.wb = wb; v.exp.wa = AW'(wa);
    v.exp.rb = rb; v.exp.ra = AW'(ra); v.exp.rv = rv;
    v.exp.b0e = b0e; v.exp.b1e = b1e; v.exp.sw = sw; v.exp.rp = rp;
    return v;
  endfunction

  function automatic obs_t sample(logic e0, logic e1);
    obs_t o;
    o.en0 = e0; o.en1 = e1;
    o.rdy = bus.wr_ready; o.wb = bus.wr_buf; o.wa = bus.wr_addr;
    o.rb = bus.rd_buf; o.ra = bus.rd_addr; o.rv = bus.rd_valid;
    o.b0e = bus.buf0_empty; o.b1e = bus.buf1_empty;
    o.sw = bus.swap; o.rp = bus.repeat_frame;
    return o;
  endfunction

  task automatic compare(string nm, obs_t want, obs_t got);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %h want %h (en0 en1 rdy wb wa rb ra rv b0e b1e sw rp)", nm, got, want);
    end
  endtask

  // drive inputs, capture wr_en before the edge, check registered outputs after it
  task automatic apply(string nm, vec_t v);
    logic e0, e1;
    obs_t want;
    bus.wr_valid    = v.wv;
    bus.frame_start = v.fs;
    bus.rd_inc      = v.ri;
    @(negedge clk);
    e0 = bus.wr_en0;
    e1 = bus.wr_en1;
    q.push_back(v.exp);
    @(posedge clk);
    #1;
    want = q.pop_front();
    compare(nm, want, sample(e0, e1));
  endtask

`ifdef PINGPONG_REPEAT_CNT_EN
  task automatic compare_cnt(string nm, logic [7:0] want);
    nvec++;
    if (bus.repeat_cnt !== want) begin
      nmis++;
      $display("FAIL %s: repeat_cnt got %0d want %0d", nm, bus.repeat_cnt, want);
    end
  endtask
`endif

  vec_t tbl [30];
  obs_t rst_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wv fs ri e0 e1 rdy wb wa rb ra rv b0e b1e sw rp
    tbl[0]  = mk(1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 1, 0, 2, 1, 0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(1, 0, 0, 1, 0, 1, 0, 3, 1, 0, 0, 0, 1, 0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0); // buf0 full
    tbl[4]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0); // claim buf1
    tbl[5]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0); // first swap
    tbl[6]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0); // rd wrap
    tbl[10] = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 1, 1, 1, 2, 0, 1, 1, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 1, 1, 1, 3, 0, 1, 1, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0); // buf1 full
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0); // starved
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0); // swap frees buf0
    tbl[18] = mk(0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0); // claim buf0
    tbl[19] = mk(0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1); // repeat, rd_addr reset
    tbl[20] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[21] = mk(1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    tbl[22] = mk(1, 0, 0, 1, 0, 1, 0, 2, 1, 0, 1, 0, 0, 0, 0);
    tbl[23] = mk(1, 0, 0, 1, 0, 1, 0, 3, 1, 0, 1, 0, 0, 0, 0);
    tbl[24] = mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1); // last word + frame_start
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0); // buf1 still shown
    tbl[26] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0); // deferred swap
    tbl[27] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[28] = mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[29] = mk(1, 0, 0, 0, 1, 1, 1, 2, 0, 0, 1, 0, 0, 0, 0);

    rst_exp = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0).exp;

    reset           = 1'b1;
    bus.wr_valid    = 1'b0;
    bus.frame_start = 1'b0;
    bus.rd_inc      = 1'b0;
    #12;
    compare("reset_state", rst_exp, sample(bus.wr_en0, bus.wr_en1));
`ifdef PINGPONG_REPEAT_CNT_EN
    compare_cnt("reset_cnt", 8'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end
`ifdef PINGPONG_REPEAT_CNT_EN
    compare_cnt("cnt_cleared_on_swap", 8'd0);
`endif

    // repeated frames while buf1 is partially filled and buf0 is shown
    for (int i = 0; i < 300; i++) begin
      apply($sformatf("repeat%0d", i),
            mk(0, 1, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0, 0, 0, 1));
    end
`ifdef PINGPONG_REPEAT_CNT_EN
    compare_cnt("cnt_saturate", 8'd255);
`endif

    // asynchronous reset in the middle of a frame (wr_addr==2)
    bus.frame_start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    compare("reset_async", rst_exp, sample(bus.wr_en0, bus.wr_en1));
    @(posedge clk);
    #1;
    compare("reset_held", rst_exp, sample(bus.wr_en0, bus.wr_en1));
`ifdef PINGPONG_REPEAT_CNT_EN
    compare_cnt("reset_cnt_mid", 8'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // after reset: writes restart in buf0; rd_inc and frame_start inert without a shown frame
    apply("post_rst_wr",  mk(1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    apply("post_rst_inc", mk(0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    apply("post_rst_fs",  mk(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
